smg_scan_driver: RTL and testbench

//  Parametrised multiplexed seven-segment scan driver for DIGITS hex digits.

---
 rtl/smg_scan_driver.sv | 154 +++++++++++++++
 tb/tb_smg_scan_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/smg_scan_driver.sv
// Multiplexed seven-segment scan driver. Latches the digit bus once per frame and scans one digit per slot.
// Build option: define SMG_LZB_EN to enable leading-zero blanking. Without it, every digit is decoded.
module smg_scan_driver #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned BLANK_CYC       = 500,
  parameter bit          SEG_ACTIVE_LOW  = 1'b1,
  parameter bit          SCAN_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   NumberSig,
  input  logic [DIGITS-1:0]     DpSig,
  output logic [7:0]            SmgData,
  output logic [DIGITS-1:0]     ScanSig,
  output logic                  FrameDone
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SCAN_OFF  = {DIGITS{SCAN_ACTIVE_LOW}};

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_shadow_num;
  logic [DIGITS-1:0]   r_shadow_dp;
  logic [7:0]          r_seg;
  logic [DIGITS-1:0]   r_scan;
  logic                r_frame_done;

  logic                w_cnt_wrap;
  logic                w_idx_wrap;
  logic                w_load;
  logic [3:0]          w_nib;
  logic                w_dp;
  logic                w_blank;
  logic [DIGITS-1:0]   w_lzb_mask;
  logic [7:0]          w_seg_al;
  logic [DIGITS-1:0]   w_scan_al;
  logic [7:0]          w_seg_nxt;
  logic [DIGITS-1:0]   w_scan_nxt;

  // Active-low segment codes {dp,g,f,e,d,c,b,a}, dp off.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] code;
    unique case (nib)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      4'hF: code = 8'h8E;
    endcase
    return code;
  endfunction

  assign w_cnt_wrap = (r_cnt == CNT_LAST);
  assign w_idx_wrap = (r_idx == IDX_LAST);
  assign w_load     = (r_idx == '0) && (r_cnt == '0);

`ifdef SMG_LZB_EN
  // Walk down from the top digit; zeros stay blanked until the first non-zero nibble.
  always_comb begin
    logic v_seen;
    v_seen     = 1'b0;
    w_lzb_mask = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (r_shadow_num[4*i +: 4] != 4'h0) begin
        v_seen = 1'b1;
      end
      w_lzb_mask[i] = ~v_seen;
    end
  end
`else
  assign w_lzb_mask = '0;
`endif

  // Select the current digit's shadow data and build the one-hot enable.
  always_comb begin
    w_nib     = 4'h0;
    w_dp      = 1'b0;
    w_blank   = 1'b0;
    w_scan_al = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib        = r_shadow_num[4*i +: 4];
        w_dp         = r_shadow_dp[i];
        w_blank      = w_lzb_mask[i];
        w_scan_al[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_seg_al = seg_decode(w_nib);
    if (w_blank) begin
      w_seg_al[6:0] = 7'h7F;
    end
    if (w_dp) begin
      w_seg_al[7] = 1'b0;
    end
    if (r_cnt < CNT_BLANK) begin
      w_seg_nxt  = SEG_OFF;
      w_scan_nxt = SCAN_OFF;
    end else begin
      w_seg_nxt  = SEG_ACTIVE_LOW ? w_seg_al : ~w_seg_al;
      w_scan_nxt = SCAN_ACTIVE_LOW ? w_scan_al : ~w_scan_al;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow_num <= '0;
      r_shadow_dp  <= '0;
      r_seg        <= SEG_OFF;
      r_scan       <= SCAN_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
      if (w_cnt_wrap) begin
        r_idx <= w_idx_wrap ? '0 : r_idx + 1'b1;
      end
      if (w_load) begin
        r_shadow_num <= NumberSig;
        r_shadow_dp  <= DpSig;
      end
      r_seg        <= w_seg_nxt;
      r_scan       <= w_scan_nxt;
      r_frame_done <= w_cnt_wrap && w_idx_wrap;
    end
  end

  assign SmgData   = r_seg;
  assign ScanSig   = r_scan;
  assign FrameDone = r_frame_done;

endmodule

// File: tb/tb_smg_scan_driver.sv
// Self-checking bench for smg_scan_driver: frame vectors feed a per-cycle scoreboard checked on negedge.
module tb_smg_scan_driver;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int          FRAME     = DIGITS * SCAN_DIV;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] NumberSig = '0;
  logic [3:0]  DpSig = '0;
  logic [7:0]  SmgData;
  logic [3:0]  ScanSig;
  logic        FrameDone;

  always #5 CLK = ~CLK;

  smg_scan_driver #(
    .DIGITS          (DIGITS),
    .SCAN_DIV        (SCAN_DIV),
    .BLANK_CYC       (BLANK_CYC),
    .SEG_ACTIVE_LOW  (1'b1),
    .SCAN_ACTIVE_LOW (1'b1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .NumberSig (NumberSig),
    .DpSig     (DpSig),
    .SmgData   (SmgData),
    .ScanSig   (ScanSig),
    .FrameDone (FrameDone)
  );

  typedef struct {
    logic [7:0]  seg;
    logic [3:0]  scan;
    logic        fd;
    logic [63:0] tag;
  } exp_t;

  typedef struct {
    logic [63:0] tag;
    logic [15:0] num;
    logic [3:0]  dp;
    logic [31:0] seg;      // {slot3, slot2, slot1, slot0}
    int          chg_at;
    logic [15:0] chg_num;
    int          abort_at;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_errors = 0;

  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (SmgData !== mon_e.seg || ScanSig !== mon_e.scan || FrameDone !== mon_e.fd) begin
        n_errors++;
        $display("FAIL %s t=%0t: got seg=%h scan=%b fd=%b, want seg=%h scan=%b fd=%b",
                 mon_e.tag, $time, SmgData, ScanSig, FrameDone, mon_e.seg, mon_e.scan, mon_e.fd);
      end
    end
  end

  function automatic vec_t mk(input logic [63:0] tag, input logic [15:0] num,
                              input logic [3:0] dp, input logic [31:0] seg);
    vec_t v;
    v.tag      = tag;
    v.num      = num;
    v.dp       = dp;
    v.seg      = seg;
    v.chg_at   = -1;
    v.chg_num  = num;
    v.abort_at = -1;
    return v;
  endfunction

  task automatic push(input logic [7:0] s, input logic [3:0] sc, input logic f,
                      input logic [63:0] tag);
    exp_t e;
    e.seg  = s;
    e.scan = sc;
    e.fd   = f;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  // Assumes the next rising edge samples the shadow (slot 0, count 0).
  task automatic run_frame(input vec_t v);
    int         cnt;
    int         idx;
    logic [3:0] sc;
    NumberSig = v.num;
    DpSig     = v.dp;
    for (int k = 0; k < FRAME; k++) begin
      if (k == v.chg_at) NumberSig = v.chg_num;
      if (k == v.abort_at) begin
        RST = 1'b1;
        @(posedge CLK);
        #1;
        push(8'hFF, 4'hF, 1'b0, v.tag);
        RST = 1'b0;
        return;
      end
      cnt = k % int'(SCAN_DIV);
      idx = k / int'(SCAN_DIV);
      @(posedge CLK);
      #1;
      if (cnt < int'(BLANK_CYC)) begin
        push(8'hFF, 4'hF, 1'b0, v.tag);
      end else begin
        sc = 4'hF;
        sc[idx] = 1'b0;
        push(v.seg[idx*8 +: 8], sc, (k == FRAME - 1), v.tag);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk("d1234", 16'h1234, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99});
    vecs[1] = mk("chg", 16'h1234, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99});
    vecs[1].chg_at  = 10;
    vecs[1].chg_num = 16'hABCD;
    vecs[2] = mk("dABCD", 16'hABCD, 4'b0000, {8'h88, 8'h83, 8'hC6, 8'hA1});
`ifdef SMG_LZB_EN
    vecs[3] = mk("dp0200", 16'h0200, 4'b0100, {8'hFF, 8'h24, 8'hC0, 8'hC0});
    vecs[4] = mk("d0070", 16'h0070, 4'b0000, {8'hFF, 8'hFF, 8'hF8, 8'hC0});
    vecs[5] = mk("dp0000", 16'h0000, 4'b1111, {8'h7F, 8'h7F, 8'h7F, 8'h40});
`else
    vecs[3] = mk("dp0200", 16'h0200, 4'b0100, {8'hC0, 8'h24, 8'hC0, 8'hC0});
    vecs[4] = mk("d0070", 16'h0070, 4'b0000, {8'hC0, 8'hC0, 8'hF8, 8'hC0});
    vecs[5] = mk("dp0000", 16'h0000, 4'b1111, {8'h40, 8'h40, 8'h40, 8'h40});
`endif
    vecs[6] = mk("d5678dp", 16'h5678, 4'b1001, {8'h12, 8'h82, 8'hF8, 8'h00});
    vecs[7] = mk("d9EF0", 16'h9EF0, 4'b0000, {8'h90, 8'h86, 8'h8E, 8'hC0});
    vecs[8] = mk("abort", 16'h1234, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99});
    vecs[8].abort_at = 20;
`ifdef SMG_LZB_EN
    vecs[9] = mk("after", 16'h0B31, 4'b0010, {8'hFF, 8'h83, 8'h30, 8'hF9});
`else
    vecs[9] = mk("after", 16'h0B31, 4'b0010, {8'hC0, 8'h83, 8'h30, 8'hF9});
`endif

    // Reset held for three cycles.
    RST = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(posedge CLK);
      #1;
      push(8'hFF, 4'hF, 1'b0, "reset");
    end
    RST = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i]);
    end

    @(negedge CLK);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
